// File: rtl/vliw_pipe_hazard_ctrl.sv
// Pipeline-register control for the two-slot VLIW pipe: load-use bubbles,
// taken-branch squash and memory freeze, plus saturating stall/flush counters.
module vliw_pipe_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int LOAD_STALL  = 1,
  parameter int FLUSH_EXTRA = 1,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs_s0,
  input  logic [REG_ADDR_W-1:0] id_rt_s0,
  input  logic [REG_ADDR_W-1:0] id_rs_s1,
  input  logic [REG_ADDR_W-1:0] id_rt_s1,
  input  logic                  id_use_rt_s0,
  input  logic                  id_use_rt_s1,
  input  logic                  ex_memread_s0,
  input  logic                  ex_memread_s1,
  input  logic [REG_ADDR_W-1:0] ex_rd_s0,
  input  logic [REG_ADDR_W-1:0] ex_rd_s1,
  input  logic                  ex_branch_taken,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  exmem_write,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH, HOLD} state_t;

  localparam logic [2:0] STALL_REM = 3'(LOAD_STALL - 1);
  localparam logic [2:0] FLUSH_REM = 3'(FLUSH_EXTRA);

  // Control vector order: {pc_write, ifid_write, exmem_write, ifid_flush, idex_flush}
  localparam logic [4:0] CTL_RESET  = 5'b00011;
  localparam logic [4:0] CTL_FREEZE = 5'b00000;
  localparam logic [4:0] CTL_RUN    = 5'b11100;
  localparam logic [4:0] CTL_BUBBLE = 5'b00101;
  localparam logic [4:0] CTL_BRANCH = 5'b11111;
  localparam logic [4:0] CTL_SQUASH = 5'b11110;

  state_t     state, savedState, nextState, nextSaved;
  logic [2:0] rem, nextRem;
  logic [4:0] ctl;
  logic       stallInc, flushInc, takeBranch;
  logic       hitS0, hitS1, loadUse;

  assign hitS0 = ex_memread_s0 && (ex_rd_s0 != '0) &&
                 ((ex_rd_s0 == id_rs_s0) || (ex_rd_s0 == id_rs_s1) ||
                  (id_use_rt_s0 && (ex_rd_s0 == id_rt_s0)) ||
                  (id_use_rt_s1 && (ex_rd_s0 == id_rt_s1)));
  assign hitS1 = ex_memread_s1 && (ex_rd_s1 != '0) &&
                 ((ex_rd_s1 == id_rs_s0) || (ex_rd_s1 == id_rs_s1) ||
                  (id_use_rt_s0 && (ex_rd_s1 == id_rt_s0)) ||
                  (id_use_rt_s1 && (ex_rd_s1 == id_rt_s1)));
  assign loadUse = hitS0 || hitS1;

  assign {pc_write, ifid_write, exmem_write, ifid_flush, idex_flush} = ctl;

  always_comb begin
    ctl        = CTL_FREEZE;
    nextState  = state;
    nextSaved  = savedState;
    nextRem    = rem;
    stallInc   = 1'b0;
    flushInc   = 1'b0;
    takeBranch = 1'b0;
    case (state)
      RUN: begin
        if (!mem_ready) begin
          nextSaved = RUN;
          nextState = HOLD;
        end else if (ex_branch_taken) begin
          takeBranch = 1'b1;
        end else if (loadUse) begin
          ctl      = CTL_BUBBLE;
          stallInc = 1'b1;
          if (LOAD_STALL > 1) begin
            nextState = STALL;
            nextRem   = STALL_REM;
          end
        end else begin
          ctl = CTL_RUN;
        end
      end
      STALL: begin
        if (!mem_ready) begin
          nextSaved = STALL;
          nextState = HOLD;
        end else if (ex_branch_taken) begin
          takeBranch = 1'b1;
        end else begin
          ctl      = CTL_BUBBLE;
          stallInc = 1'b1;
          nextRem  = rem - 3'd1;
          if (rem <= 3'd1) nextState = RUN;
        end
      end
      FLUSH: begin
        // EX holds a squashed op here, so a taken branch is meaningless.
        if (!mem_ready) begin
          nextSaved = FLUSH;
          nextState = HOLD;
        end else begin
          ctl     = CTL_SQUASH;
          nextRem = rem - 3'd1;
          if (rem <= 3'd1) nextState = RUN;
        end
      end
      HOLD: begin
        if (mem_ready) nextState = savedState;
      end
      default: nextState = RUN;
    endcase

    if (takeBranch) begin
      ctl      = CTL_BRANCH;
      flushInc = 1'b1;
      if (FLUSH_EXTRA > 0) begin
        nextState = FLUSH;
        nextRem   = FLUSH_REM;
      end else begin
        nextState = RUN;
      end
    end

    if (!reset) ctl = CTL_RESET;
  end

  always_ff @(negedge clk) begin
    if (!reset) begin
      state      <= RUN;
      savedState <= RUN;
      rem        <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      state      <= nextState;
      savedState <= nextSaved;
      rem        <= nextRem;
      if (stallInc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flushInc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_vliw_pipe_hazard_ctrl.sv
// Scenario bench for vliw_pipe_hazard_ctrl: expected control vectors and
// counter values are queued per cycle and compared mid-cycle on the rising edge.
module tb_vliw_pipe_hazard_ctrl;

  localparam int REG_ADDR_W  = 5;
  localparam int LOAD_STALL  = 3;
  localparam int FLUSH_EXTRA = 2;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  localparam logic [4:0] V_RESET  = 5'b00011;
  localparam logic [4:0] V_FREEZE = 5'b00000;
  localparam logic [4:0] V_RUN    = 5'b11100;
  localparam logic [4:0] V_BUBBLE = 5'b00101;
  localparam logic [4:0] V_BRANCH = 5'b11111;
  localparam logic [4:0] V_SQUASH = 5'b11110;

  logic clk, reset;
  logic [REG_ADDR_W-1:0] id_rs_s0, id_rt_s0, id_rs_s1, id_rt_s1, ex_rd_s0, ex_rd_s1;
  logic id_use_rt_s0, id_use_rt_s1, ex_memread_s0, ex_memread_s1;
  logic ex_branch_taken, mem_ready;
  logic pc_write, ifid_write, exmem_write, ifid_flush, idex_flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [4:0] obsVec;

  typedef struct {
    logic [4:0]       vec;
    logic [CNT_W-1:0] st;
    logic [CNT_W-1:0] fl;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int expStall;

  assign obsVec = {pc_write, ifid_write, exmem_write, ifid_flush, idex_flush};

  vliw_pipe_hazard_ctrl #(
    .REG_ADDR_W(REG_ADDR_W), .LOAD_STALL(LOAD_STALL),
    .FLUSH_EXTRA(FLUSH_EXTRA), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .id_rs_s0(id_rs_s0), .id_rt_s0(id_rt_s0), .id_rs_s1(id_rs_s1), .id_rt_s1(id_rt_s1),
    .id_use_rt_s0(id_use_rt_s0), .id_use_rt_s1(id_use_rt_s1),
    .ex_memread_s0(ex_memread_s0), .ex_memread_s1(ex_memread_s1),
    .ex_rd_s0(ex_rd_s0), .ex_rd_s1(ex_rd_s1),
    .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .exmem_write(exmem_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sat(input int x);
    return (x > CNT_MAX) ? CNT_MAX : x;
  endfunction

  // Inputs are already driven; queue the expectation, compare on the rising
  // edge, then let the falling edge update the DUT state.
  task automatic step(input logic [4:0] v, input int st, input int fl, input string nm);
    exp_t e;
    e.vec = v;
    e.st  = st[CNT_W-1:0];
    e.fl  = fl[CNT_W-1:0];
    sb.push_back(e);
    @(posedge clk);
    e = sb.pop_front();
    total++;
    if (obsVec !== e.vec) begin
      bad++;
      $display("FAIL %s ctl: got %b want %b", nm, obsVec, e.vec);
    end
    total++;
    if (stall_cnt !== e.st) begin
      bad++;
      $display("FAIL %s stall_cnt: got %0d want %0d", nm, stall_cnt, e.st);
    end
    total++;
    if (flush_cnt !== e.fl) begin
      bad++;
      $display("FAIL %s flush_cnt: got %0d want %0d", nm, flush_cnt, e.fl);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic clearInputs();
    id_rs_s0 = 5'd1; id_rt_s0 = 5'd2; id_rs_s1 = 5'd3; id_rt_s1 = 5'd5;
    id_use_rt_s0 = 1'b0; id_use_rt_s1 = 1'b0;
    ex_memread_s0 = 1'b0; ex_memread_s1 = 1'b0;
    ex_rd_s0 = 5'd0; ex_rd_s1 = 5'd0;
    ex_branch_taken = 1'b0;
    mem_ready = 1'b1;
  endtask

  task automatic applyReset();
    clearInputs();
    reset = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic setHazardA();
    id_rt_s0 = 5'd7; id_use_rt_s0 = 1'b1;
    ex_memread_s1 = 1'b1; ex_rd_s1 = 5'd7;
  endtask

  task automatic test_reset();
    clearInputs();
    reset = 1'b0;
    step(V_RESET, 0, 0, "reset_hold0");
    step(V_RESET, 0, 0, "reset_hold1");
    reset = 1'b1;
    step(V_RUN, 0, 0, "reset_run0");
    step(V_RUN, 0, 0, "reset_run1");
  endtask

  task automatic loadUseCase(input string nm,
                             input logic [4:0] rs0, input logic [4:0] rt0,
                             input logic [4:0] rs1, input logic [4:0] rt1,
                             input logic u0, input logic u1,
                             input logic m0, input logic [4:0] rd0,
                             input logic m1, input logic [4:0] rd1,
                             input bit hazard);
    id_rs_s0 = rs0; id_rt_s0 = rt0; id_rs_s1 = rs1; id_rt_s1 = rt1;
    id_use_rt_s0 = u0; id_use_rt_s1 = u1;
    ex_memread_s0 = m0; ex_rd_s0 = rd0;
    ex_memread_s1 = m1; ex_rd_s1 = rd1;
    if (hazard) begin
      for (int k = 0; k < LOAD_STALL; k++) begin
        step(V_BUBBLE, expStall, 0, nm);
        expStall = sat(expStall + 1);
      end
      clearInputs();
      step(V_RUN, expStall, 0, nm);
    end else begin
      step(V_RUN, expStall, 0, nm);
      clearInputs();
    end
  endtask

  task automatic test_load_use();
    applyReset();
    expStall = 0;
    loadUseCase("lu_rt0_vs_ex1", 1, 7, 3, 5, 1, 0, 0, 0, 1, 7, 1'b1);
    loadUseCase("lu_r0_ignored", 1, 0, 3, 5, 1, 0, 0, 0, 1, 0, 1'b0);
    loadUseCase("lu_rt_unused",  1, 7, 3, 5, 0, 0, 0, 0, 1, 7, 1'b0);
    loadUseCase("lu_rs1_vs_ex0", 1, 2, 9, 5, 0, 0, 1, 9, 0, 0, 1'b1);
    loadUseCase("lu_not_load",   1, 2, 9, 5, 0, 0, 0, 9, 0, 0, 1'b0);
    loadUseCase("lu_rt1_vs_ex0", 1, 2, 3, 12, 0, 1, 1, 12, 0, 0, 1'b1);
    loadUseCase("lu_rs0_vs_ex1", 4, 2, 3, 5, 0, 0, 0, 0, 1, 4, 1'b1);
  endtask

  task automatic test_branch();
    applyReset();
    ex_branch_taken = 1'b1;
    step(V_BRANCH, 0, 0, "br_pulse");
    ex_branch_taken = 1'b0;
    for (int k = 0; k < FLUSH_EXTRA; k++) step(V_SQUASH, 0, 1, "br_squash");
    step(V_RUN, 0, 1, "br_back_run");
    // branch held: FLUSH ignores it, RUN takes it again
    ex_branch_taken = 1'b1;
    step(V_BRANCH, 0, 1, "br_held0");
    for (int k = 0; k < FLUSH_EXTRA; k++) step(V_SQUASH, 0, 2, "br_held_squash");
    step(V_BRANCH, 0, 2, "br_held1");
    ex_branch_taken = 1'b0;
    for (int k = 0; k < FLUSH_EXTRA; k++) step(V_SQUASH, 0, 3, "br_tail_squash");
    step(V_RUN, 0, 3, "br_tail_run");
  endtask

  task automatic test_branch_load_use();
    applyReset();
    setHazardA();
    ex_branch_taken = 1'b1;
    step(V_BRANCH, 0, 0, "bl_same_cycle");
    clearInputs();
    for (int k = 0; k < FLUSH_EXTRA; k++) step(V_SQUASH, 0, 1, "bl_squash");
    step(V_RUN, 0, 1, "bl_run");
    // branch arriving mid-stall aborts the stall
    setHazardA();
    step(V_BUBBLE, 0, 1, "bl_first_bubble");
    ex_branch_taken = 1'b1;
    step(V_BRANCH, 1, 1, "bl_abort_stall");
    clearInputs();
    for (int k = 0; k < FLUSH_EXTRA; k++) step(V_SQUASH, 1, 2, "bl_abort_squash");
    step(V_RUN, 1, 2, "bl_abort_run");
  endtask

  task automatic test_hold();
    applyReset();
    setHazardA();
    step(V_BUBBLE, 0, 0, "hold_bubble0");
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) step(V_FREEZE, 1, 0, "hold_stall_frozen");
    mem_ready = 1'b1;
    step(V_FREEZE, 1, 0, "hold_release");
    for (int k = 1; k < LOAD_STALL; k++) step(V_BUBBLE, k, 0, "hold_bubble_resume");
    clearInputs();
    step(V_RUN, LOAD_STALL, 0, "hold_stall_done");
    mem_ready = 1'b0;
    step(V_FREEZE, LOAD_STALL, 0, "hold_from_run");
    mem_ready = 1'b1;
    ex_branch_taken = 1'b1;
    step(V_FREEZE, LOAD_STALL, 0, "hold_branch_ignored");
    ex_branch_taken = 1'b0;
    step(V_RUN, LOAD_STALL, 0, "hold_run_resume");
    ex_branch_taken = 1'b1;
    step(V_BRANCH, LOAD_STALL, 0, "hold_flush_branch");
    ex_branch_taken = 1'b0;
    mem_ready = 1'b0;
    step(V_FREEZE, LOAD_STALL, 1, "hold_flush_frozen");
    mem_ready = 1'b1;
    step(V_FREEZE, LOAD_STALL, 1, "hold_flush_release");
    for (int k = 0; k < FLUSH_EXTRA; k++) step(V_SQUASH, LOAD_STALL, 1, "hold_flush_resume");
    step(V_RUN, LOAD_STALL, 1, "hold_flush_done");
  endtask

  task automatic test_saturation();
    int per;
    applyReset();
    // 20 back-to-back load-use events: the held hazard re-arms after each stall
    setHazardA();
    for (int k = 0; k < 20 * LOAD_STALL; k++) step(V_BUBBLE, sat(k), 0, "sat_stall");
    clearInputs();
    step(V_RUN, CNT_MAX, 0, "sat_stall_done");
    per = 1 + FLUSH_EXTRA;
    ex_branch_taken = 1'b1;
    for (int k = 0; k < 20 * per; k++) begin
      if (k % per == 0) step(V_BRANCH, CNT_MAX, sat(k / per), "sat_flush_br");
      else              step(V_SQUASH, CNT_MAX, sat(k / per + 1), "sat_flush_sq");
    end
    step(V_BRANCH, CNT_MAX, CNT_MAX, "sat_enter_flush");
    ex_branch_taken = 1'b0;
    reset = 1'b0;
    step(V_RESET, CNT_MAX, CNT_MAX, "mid_flush_reset");
    reset = 1'b1;
    step(V_RUN, 0, 0, "mid_flush_after_reset");
  endtask

  initial begin
    clearInputs();
    reset = 1'b0;
    @(negedge clk);
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_branch_load_use();
    test_hold();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
